// File: rtl/sat_accum.sv
// Saturating multi-operand accumulator built around a 16-bit saturating CLA adder.
// Optional overflow statistics counter (ovf_cnt) enabled by SAT_ACCUM_STATS_EN.
//
// state   | meaning
// --------+--------------------------------------------------------
// S_IDLE  | waiting for start; input and output channels closed
// S_ACCUM | accepting operands, one adder step per handshake
// S_DONE  | result presented, held until the consumer accepts it

module cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum,
    output logic        OvrFlow
);
    logic [15:0] b_eff;
    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic [4:0]  cb;
    logic [3:0]  blk_g;
    logic [3:0]  blk_p;
    logic [15:0] raw;

    assign b_eff = b ^ {16{sub}};
    assign g     = a & b_eff;
    assign p     = a ^ b_eff;

    // Four 4-bit lookahead blocks chained through block generate/propagate.
    always_comb begin
        cb    = '0;
        c     = '0;
        blk_g = '0;
        blk_p = '0;
        cb[0] = sub;
        for (int k = 0; k < 4; k++) begin
            blk_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            blk_p[k] = &p[4*k +: 4];
            cb[k+1]  = blk_g[k] | (blk_p[k] & cb[k]);
        end
        for (int k = 0; k < 4; k++) begin
            c[4*k] = cb[k];
            for (int i = 0; i < 3; i++) begin
                c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
            end
        end
        c[16] = cb[4];
    end

    assign raw     = p ^ c[15:0];
    assign OvrFlow = (a[15] == b_eff[15]) && (raw[15] != a[15]);
    assign sum     = OvrFlow ? (a[15] ? 16'h8000 : 16'h7FFF) : raw;
endmodule

module sat_accum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  len,
    input  logic [15:0] init,
    input  logic        sub,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_ovf,
    input  logic        out_ready,
`ifdef SAT_ACCUM_STATS_EN
    output logic [4:0]  ovf_cnt,
`endif
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic        sub_q, sub_d;
    logic [3:0]  rem_q, rem_d;
    logic        ovf_q, ovf_d;
    logic [15:0] step_sum;
    logic        step_ovf;
    logic        in_hs;

    cla_16bit u_cla (
        .a       (acc_q),
        .b       (in_data),
        .sub     (sub_q),
        .sum     (step_sum),
        .OvrFlow (step_ovf)
    );

    assign in_hs = (state_q == S_ACCUM) && in_valid;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sub_d   = sub_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = init;
                    sub_d   = sub;
                    rem_d   = len;
                    ovf_d   = 1'b0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    acc_d = step_sum;
                    ovf_d = ovf_q | step_ovf;
                    if (rem_q == 4'd0) state_d = S_DONE;
                    else               rem_d   = rem_q - 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            sub_q   <= 1'b0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sub_q   <= sub_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef SAT_ACCUM_STATS_EN
    logic [4:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == S_IDLE) && start)          cnt_d = 5'd0;
        else if (in_hs && step_ovf && cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign ovf_cnt = cnt_q;
`endif

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_sat_accum.sv
// Scoreboard bench for sat_accum: driver pushes expected results, monitor pops on output handshake.
module tb_sat_accum;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  len;
    logic [15:0] init;
    logic        sub;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        out_ready;
    logic        busy;
    logic [4:0]  ovf_cnt_w;

    typedef struct packed {
        logic [15:0] data;
        logic        ovf;
        logic [4:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] ops[16];

    sat_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .init      (init),
        .sub       (sub),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_ready (out_ready),
`ifdef SAT_ACCUM_STATS_EN
        .ovf_cnt   (ovf_cnt_w),
`endif
        .busy      (busy)
    );

`ifndef SAT_ACCUM_STATS_EN
    assign ovf_cnt_w = 5'd0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compare each accepted result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got 0x%0h expected none", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
`ifdef SAT_ACCUM_STATS_EN
                chk("ovf_cnt", 32'(ovf_cnt_w), 32'(e.cnt));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [3:0] l, input logic [15:0] ini, input logic s,
                       input bit stall, input bit hold,
                       input logic [15:0] exp_d, input logic exp_o, input logic [4:0] exp_c);
        int guard;
        guard = 0;
        while (busy && guard < 50) begin
            tick();
            guard++;
        end
        chk("idle_before_start", 32'(busy), 32'd0);
        sb.push_back('{data: exp_d, ovf: exp_o, cnt: exp_c});
        out_ready = hold ? 1'b0 : 1'b1;
        start = 1'b1; len = l; init = ini; sub = s;
        tick();
        start = 1'b0; len = 4'd0; init = 16'h0; sub = 1'b0;
        chk("in_ready_after_start", 32'(in_ready), 32'd1);
        for (int k = 0; k <= int'(l); k++) begin
            if (stall) begin
                int n;
                n = $urandom_range(0, 3);
                in_valid = 1'b0;
                for (int j = 0; j < n; j++) tick();
                chk("no_early_done", 32'(out_valid), 32'd0);
            end
            in_valid = 1'b1;
            in_data  = ops[k];
            tick();
        end
        in_valid = 1'b0;
        in_data  = 16'h0;
        chk("out_valid_latency", 32'(out_valid), 32'd1);
        if (hold) begin
            for (int j = 0; j < 10; j++) begin
                start = 1'b1;
                tick();
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(exp_d));
                chk("hold_ovf", 32'(out_ovf), 32'(exp_o));
                chk("hold_busy", 32'(busy), 32'd1);
            end
            out_ready = 1'b1;
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("start_on_done_hs_ignored", 32'(busy), 32'd0);
            chk("in_ready_idle", 32'(in_ready), 32'd0);
        end else begin
            tick();
            chk("idle_after_hs", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; len = 4'd0; init = 16'h0; sub = 1'b0;
        in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) ops[i] = 16'h0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef SAT_ACCUM_STATS_EN
        chk("rst_ovf_cnt", 32'(ovf_cnt_w), 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        ops[0] = 16'd1; ops[1] = 16'd2; ops[2] = 16'd3; ops[3] = 16'd4;
        run(4'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h000A, 1'b0, 5'd0);
        run(4'd3, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h000A, 1'b0, 5'd0);

        ops[0] = 16'h0800; ops[1] = 16'h0800; ops[2] = 16'hF000;
        run(4'd2, 16'h7000, 1'b0, 1'b0, 1'b0, 16'h6FFF, 1'b1, 5'd1);

        ops[0] = 16'h0003; ops[1] = 16'h0010;
        run(4'd1, 16'h8005, 1'b1, 1'b0, 1'b1, 16'h8000, 1'b1, 5'd1);

        ops[0] = 16'h8000;
        run(4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b1, 5'd1);

        for (int i = 0; i < 16; i++) ops[i] = 16'h1000;
        run(4'd15, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b1, 5'd9);

        // Abort an 8-operand run after two operands.
        start = 1'b1; len = 4'd7; init = 16'h1234; sub = 1'b0;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'h0100;
        tick();
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_out_ovf", 32'(out_ovf), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        ops[0] = 16'd7;
        run(4'd0, 16'd5, 1'b0, 1'b0, 1'b0, 16'h000C, 1'b0, 5'd0);

        tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
